// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: FSM encoding,
// well-known scan code prefixes and the frame acceptance rule.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    localparam logic [3:0] LAST_DATA_BIT = 4'd7;

    // A frame is accepted when the stop bit is high and data plus parity
    // carry an odd number of ones.
    function automatic logic frame_ok(input logic [7:0] data,
                                      input logic       parity,
                                      input logic       stop);
        return stop & (^{data, parity});
    endfunction

endpackage

// File: rtl/ps2_input_filter.sv
// Conditions the raw PS/2 pins: two-stage synchronizers on both lines,
// a saturating glitch filter on the clock and a falling-edge strobe.
module ps2_input_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_dat,
    output logic fall,
    output logic dat_s
);

    localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          clk_s;
    logic          clk_f;
    logic [CW-1:0] cnt;

    // Bring both asynchronous pins into the system clock domain; idle level is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_dat};
        end
    end

    assign clk_s = clk_sync[1];
    assign dat_s = dat_sync[1];

    // Flip the filtered clock only after FILTER_LEN consecutive disagreeing samples,
    // and strobe fall in the cycle the filtered clock drops to 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_f <= 1'b1;
            cnt   <= '0;
            fall  <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_s == clk_f) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                clk_f <= clk_s;
                cnt   <= '0;
                fall  <= ~clk_s;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: frames start/data/parity/stop bits sampled on the
// filtered clock's falling edge and keeps a two-byte scan code history.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        PS2_CLK,
    input  logic        PS2_DAT,
    output logic [15:0] key_press,
    output logic        key_valid,
    output logic        frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic fall;
    logic dat_s;

    ps2_state_t    state, state_nxt;
    logic [3:0]    bit_cnt, bit_cnt_nxt;
    logic [7:0]    shift_reg, shift_reg_nxt;
    logic          parity_bit, parity_bit_nxt;
    logic [TW-1:0] to_cnt, to_cnt_nxt;
    logic [15:0]   key_press_nxt;
    logic          key_valid_nxt;
    logic          frame_err_nxt;

    ps2_input_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_filter (
        .clk    (CLOCK_50),
        .reset  (reset),
        .ps2_clk(PS2_CLK),
        .ps2_dat(PS2_DAT),
        .fall   (fall),
        .dat_s  (dat_s)
    );

    // Register the frame state, timeout counter, history and output pulses.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            to_cnt     <= '0;
            key_press  <= 16'h0000;
            key_valid  <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shift_reg  <= shift_reg_nxt;
            parity_bit <= parity_bit_nxt;
            to_cnt     <= to_cnt_nxt;
            key_press  <= key_press_nxt;
            key_valid  <= key_valid_nxt;
            frame_err  <= frame_err_nxt;
        end
    end

    // Advance the frame on each falling edge; an edge always beats a
    // simultaneous timeout, and the timer is parked at zero while idle.
    always_comb begin
        state_nxt      = state;
        bit_cnt_nxt    = bit_cnt;
        shift_reg_nxt  = shift_reg;
        parity_bit_nxt = parity_bit;
        to_cnt_nxt     = to_cnt;
        key_press_nxt  = key_press;
        key_valid_nxt  = 1'b0;
        frame_err_nxt  = 1'b0;

        if (state == ST_IDLE) begin
            to_cnt_nxt = '0;
            if (fall && !dat_s) begin
                bit_cnt_nxt   = '0;
                shift_reg_nxt = '0;
                state_nxt     = ST_DATA;
            end
        end else if (fall) begin
            to_cnt_nxt = '0;
            case (state)
                ST_DATA: begin
                    shift_reg_nxt = {dat_s, shift_reg[7:1]};
                    bit_cnt_nxt   = bit_cnt + 4'd1;
                    if (bit_cnt >= LAST_DATA_BIT) begin
                        state_nxt = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    parity_bit_nxt = dat_s;
                    state_nxt      = ST_STOP;
                end
                ST_STOP: begin
                    if (frame_ok(shift_reg, parity_bit, dat_s)) begin
                        key_press_nxt = {key_press[7:0], shift_reg};
                        key_valid_nxt = 1'b1;
                    end else begin
                        frame_err_nxt = 1'b1;
                    end
                    state_nxt = ST_IDLE;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end else if (to_cnt >= TW'(TIMEOUT_CYCLES)) begin
            to_cnt_nxt    = '0;
            state_nxt     = ST_IDLE;
            frame_err_nxt = 1'b1;
        end else begin
            to_cnt_nxt = to_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Scoreboard bench for ps2_keyboard_rx: stimulus pushes the expected
// pulse into a queue, a monitor pops and compares on every output pulse.
module tb_ps2_keyboard_rx;
    import ps2_pkg::*;

    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 2000;
    localparam int HALF           = 50;

    logic        CLOCK_50;
    logic        reset;
    logic        PS2_CLK;
    logic        PS2_DAT;
    logic [15:0] key_press;
    logic        key_valid;
    logic        frame_err;

    typedef struct {
        logic        is_err;
        logic [15:0] kp;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] model_kp;
    int          tests;
    int          fails;

    ps2_keyboard_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .PS2_CLK  (PS2_CLK),
        .PS2_DAT  (PS2_DAT),
        .key_press(key_press),
        .key_valid(key_valid),
        .frame_err(frame_err)
    );

    // 50 MHz system clock
    initial begin
        CLOCK_50 = 1'b0;
        forever #10 CLOCK_50 = ~CLOCK_50;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference rule: odd parity over data+parity and a high stop bit accept the byte.
    task automatic expectFrame(input logic [7:0] b, input logic par, input logic stp);
        exp_t e;
        logic ones_odd;
        ones_odd = 1'b0;
        for (int i = 0; i < 8; i++) ones_odd = ones_odd ^ b[i];
        if (stp == 1'b1 && (ones_odd != par)) begin
            model_kp = {model_kp[7:0], b};
            e.is_err = 1'b0;
        end else begin
            e.is_err = 1'b1;
        end
        e.kp = model_kp;
        exp_q.push_back(e);
    endtask

    // Device-driven frame: data changes while clock is high, host samples on the fall.
    task automatic applyStimulus(input logic [7:0] b, input logic par, input logic stp,
                                 input int half, input int nbits);
        logic [10:0] bits;
        bits = {stp, par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge CLOCK_50);
            PS2_DAT = bits[i];
            repeat (half) @(negedge CLOCK_50);
            PS2_CLK = 1'b0;
            repeat (half) @(negedge CLOCK_50);
            PS2_CLK = 1'b1;
        end
        @(negedge CLOCK_50);
        PS2_DAT = 1'b1;
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge CLOCK_50);
            n++;
        end
        checkOutput({name, " pulse seen"}, exp_q.size(), 0);
        exp_q.delete();
        checkOutput({name, " key_press"}, key_press, model_kp);
    endtask

    task automatic sendAndCheck(input string name, input logic [7:0] b,
                                input logic par, input logic stp, input int half);
        expectFrame(b, par, stp);
        applyStimulus(b, par, stp, half, 11);
        repeat (5) @(negedge CLOCK_50);
        waitDrain(name);
    endtask

    function automatic logic oddPar(input logic [7:0] b);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return (ones % 2 == 0);
    endfunction

    // Monitor: every output pulse must match the oldest expected response.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLOCK_50);
            if (key_valid && frame_err) begin
                tests++;
                fails++;
                $display("[TB] FAIL pulse exclusivity: key_valid=1 frame_err=1, expected at most one");
            end
            if (key_valid || frame_err) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected pulse: key_valid=%0b frame_err=%0b key_press=0x%h, expected none",
                             key_valid, frame_err, key_press);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("pulse kind (frame_err)", 32'(frame_err), 32'(e.is_err));
                    checkOutput("key_press at pulse", 32'(key_press), 32'(e.kp));
                end
            end
        end
    end

    // Main stimulus sequence: directed cases followed by randomized frames.
    initial begin
        logic [7:0] b;
        logic       par;
        logic       stp;
        int         mode;
        int         half;

        tests    = 0;
        fails    = 0;
        model_kp = 16'h0000;
        reset    = 1'b1;
        PS2_CLK  = 1'b1;
        PS2_DAT  = 1'b1;
        repeat (5) @(negedge CLOCK_50);
        checkOutput("reset key_press", key_press, 16'h0000);
        checkOutput("reset key_valid", key_valid, 0);
        checkOutput("reset frame_err", frame_err, 0);
        reset = 1'b0;
        repeat (5) @(negedge CLOCK_50);

        sendAndCheck("single 0x16", 8'h16, 1'b0, 1'b1, HALF);
        sendAndCheck("break F0", PS2_BREAK, oddPar(PS2_BREAK), 1'b1, HALF);
        sendAndCheck("break 16", 8'h16, 1'b0, 1'b1, HALF);
        checkOutput("break history", key_press, 16'hF016);
        sendAndCheck("bad parity 1E", 8'h1E, 1'b0, 1'b1, HALF);
        sendAndCheck("bad stop 25", 8'h25, oddPar(8'h25), 1'b0, HALF);

        // Truncated frame: start plus four data bits, then silence past the timeout.
        exp_q.push_back('{is_err: 1'b1, kp: model_kp});
        applyStimulus(8'h0F, 1'b0, 1'b1, HALF, 5);
        repeat (TIMEOUT_CYCLES + 10) @(negedge CLOCK_50);
        checkOutput("timeout err seen", exp_q.size(), 0);
        checkOutput("timeout state idle", 32'(dut.state), 32'(ST_IDLE));
        exp_q.delete();
        sendAndCheck("after timeout 1C", 8'h1C, oddPar(8'h1C), 1'b1, HALF);
        checkOutput("after timeout low byte", key_press[7:0], 8'h1C);

        // Short clock glitch in idle must not be seen as an edge.
        @(negedge CLOCK_50);
        PS2_CLK = 1'b0;
        repeat (FILTER_LEN - 2) @(negedge CLOCK_50);
        PS2_CLK = 1'b1;
        repeat (30) @(negedge CLOCK_50);
        checkOutput("glitch state idle", 32'(dut.state), 32'(ST_IDLE));
        checkOutput("glitch key_press", key_press, model_kp);

        // Reset during bit 5 aborts the frame silently.
        applyStimulus(8'hA5, 1'b0, 1'b1, HALF, 6);
        PS2_DAT = 1'b1;
        repeat (10) @(negedge CLOCK_50);
        reset = 1'b1;
        repeat (4) @(negedge CLOCK_50);
        reset = 1'b0;
        model_kp = 16'h0000;
        repeat (20) @(negedge CLOCK_50);
        checkOutput("mid-frame reset key_press", key_press, 16'h0000);
        checkOutput("mid-frame reset state", 32'(dut.state), 32'(ST_IDLE));
        sendAndCheck("after reset 15", 8'h15, oddPar(8'h15), 1'b1, HALF);
        checkOutput("after reset history", key_press, 16'h0015);

        // Randomized frames with occasional parity or stop corruption.
        for (int n = 0; n < 24; n++) begin
            b    = 8'($urandom_range(0, 255));
            mode = int'($urandom_range(0, 9));
            half = int'($urandom_range(15, 40));
            par  = oddPar(b);
            stp  = 1'b1;
            if (mode < 2) par = ~par;
            else if (mode == 2) stp = 1'b0;
            sendAndCheck("random frame", b, par, stp, half);
        end

        repeat (50) @(negedge CLOCK_50);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard_rx.md
# ps2_keyboard_rx

Receives PS/2 keyboard frames from the board's PS2_CLK/PS2_DAT pins, checks framing and odd parity, and shifts each accepted scan byte into a 16-bit history register. The output `key_press[15:8]` holds the previous byte and `key_press[7:0]` holds the newest byte. This block sits directly upstream of the tone decoder and display stage, which consume `key_press` to detect make codes and break prefixes (F0). Device-to-host only; the block never drives the PS/2 lines.

## Interface
- `FILTER_LEN`, default 8: consecutive identical samples required before the filtered PS2_CLK changes level.
- `TIMEOUT_CYCLES`, default 50000: idle cycles allowed between falling edges inside a frame (1 ms at 50 MHz).
- `CLOCK_50`  input  1  system clock; the only clock.
- `reset`  input  1  synchronous, active-high reset.
- `PS2_CLK`  input  1  raw keyboard clock, asynchronous.
- `PS2_DAT`  input  1  raw keyboard data, asynchronous.
- `key_press`  output  16  scan history `{previous byte, newest byte}`.
- `key_valid`  output  1  one-cycle pulse when `key_press` takes a new byte.
- `frame_err`  output  1  one-cycle pulse when a frame is discarded.

## Operation
- **Input conditioning:**
  - Each of PS2_CLK and PS2_DAT passes through a 2-FF synchronizer.
  - The synchronized clock feeds a saturating glitch filter. The filtered clock flips only after `FILTER_LEN` consecutive samples that differ from its current level.
  - `fall` is a one-cycle strobe on a 1→0 transition of the filtered clock.
- **Sampling:** the synchronized data is sampled on `fall`. Every state transition below occurs only on `fall`.
- **FSM states:** IDLE, DATA, PARITY, STOP.
  - IDLE: if the sampled bit is 0 (start bit), clear the bit counter, clear the shift register, and go to DATA. A sampled 1 is ignored.
  - DATA: shift the sample in LSB first and increment the counter. After the 8th bit, go to PARITY.
  - PARITY: store the sample and go to STOP.
  - STOP: the frame is good when the stop bit is 1 and XOR(data, parity) = 1. A good frame gives `key_press <= {key_press[7:0], byte}` and pulses `key_valid`. A bad frame leaves `key_press` unchanged and pulses `frame_err`. Either way, return to IDLE.
- **Timeout:**
  - In any state other than IDLE, a counter clears on every `fall` and otherwise increments.
  - When the counter reaches `TIMEOUT_CYCLES`, go to IDLE and pulse `frame_err`.
  - The counter is held at 0 while in IDLE.
- **No decoding:** the block does not decode bytes. F0 and E0 are shifted in like any other byte.
- **Reset values:** `key_press` = 16'h0000, `key_valid` = 0, `frame_err` = 0, FSM = IDLE, all counters = 0, filtered clock = 1, synchronizers = 1.

## Timing
- **Edge detection latency:** a raw PS2_CLK fall is seen as `fall` 2 + `FILTER_LEN` cycles later.
- **Output update:** `key_press` and `key_valid` update on the clock edge that consumes the stop-bit `fall`. `key_valid` is high in the first cycle the new value is visible. `frame_err` behaves the same way when a frame is rejected.
- **Output stability:** `key_press` holds its value indefinitely between accepted frames.
- **Pulse exclusivity:** `key_valid` and `frame_err` are never high in the same cycle.
- **Timeout/edge collision:** if `fall` and timeout expiry occur in the same cycle, `fall` wins. The counter clears and no error is raised.
- **Reset mid-frame:** reset aborts the frame with no `frame_err`. The next start bit begins a clean frame.
- **Wrap-around:** the bit counter is 4 bits and is never allowed to exceed 8.

## Structure
- **Package `ps2_pkg`:** FSM state encoding, `PS2_BREAK` = 8'hF0, `PS2_EXT` = 8'hE0.
- **Sub-module `ps2_input_filter`:** synchronizers, glitch filter, and `fall` strobe. Parameter `FILTER_LEN`; outputs `fall` and `dat_s`.
- **Top level:** FSM, shift register, parity/stop check, timeout counter, history register.

## Test plan
- **Single byte:** from reset, send 0x16 as start 0, data 0,1,1,0,1,0,0,0, parity 0, stop 1, with a bit period of 4000 cycles. Expect `key_press` = 16'h0016 and exactly one `key_valid` pulse.
- **Break sequence:** send 0xF0 then 0x16 back to back. Expect `key_press` = 16'h16F0, then 16'hF016, with two `key_valid` pulses and no `frame_err`.
- **Bad parity:** send 0x1E with parity bit 0 (the correct value is 1). Expect one `frame_err` pulse, `key_press` unchanged, and no `key_valid`.
- **Bad stop bit:** send 0x25 with stop bit 0. Expect one `frame_err` pulse and `key_press` unchanged.
- **Timeout recovery:** stop after 4 data bits and hold PS2_CLK high for `TIMEOUT_CYCLES` + 10 cycles. Expect one `frame_err` pulse and FSM = IDLE. Then send 0x1C; expect `key_press[7:0]` = 0x1C with `key_valid`.
- **Glitch and reset:**
  - In IDLE, drive a PS2_CLK low pulse of `FILTER_LEN` - 2 cycles. Expect no state change.
  - Assert `reset` during bit 5 of a frame. Expect `key_press` = 0 and no pulses.
  - After reset, send 0x15. Expect `key_press` = 16'h0015.
